// File: rtl/dual_addressable_register.sv
// Four-entry register file with explicit or pointer-based write addressing.
// Supports hold, write, clear and demux modes plus an auto-incrementing pointer.
module dual_addressable_register #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] data,
    input  logic             enable_n,
    input  logic             clear_n,
    input  logic             use_ptr,
    input  logic             ptr_load,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [1:0]       ptr,
    output logic             wrap
);

    localparam logic [1:0] MODE_HOLD  = 2'b11;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b01;
    localparam logic [1:0] MODE_DEMUX = 2'b00;

    logic [WIDTH-1:0] ent [4];
    logic [1:0]       addr;
    logic [1:0]       mode;
    logic             write_cycle;
    logic             bump;

    assign mode        = {clear_n, enable_n};
    assign addr        = use_ptr ? ptr : sel;
    assign write_cycle = (mode == MODE_WRITE) || (mode == MODE_DEMUX);
    assign bump        = write_cycle && use_ptr && !ptr_load;

    assign out0 = ent[0];
    assign out1 = ent[1];
    assign out2 = ent[2];
    assign out3 = ent[3];

    // Entry storage: apply the selected mode to all four entries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) ent[i] <= '0;
        end else begin
            case (mode)
                MODE_WRITE: ent[addr] <= data;
                MODE_CLEAR: begin
                    for (int i = 0; i < 4; i++) ent[i] <= '0;
                end
                MODE_DEMUX: begin
                    for (int i = 0; i < 4; i++)
                        ent[i] <= (addr == 2'(i)) ? data : '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    // Pointer: a load beats the increment; wrap flags a 3->0 increment only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr  <= 2'd0;
            wrap <= 1'b0;
        end else begin
            if (ptr_load)
                ptr <= sel;
            else if (bump)
                ptr <= ptr + 2'd1;
            wrap <= bump && (ptr == 2'd3);
        end
    end

endmodule

// File: doc/dual_addressable_register.md
DUAL_ADDRESSABLE_REGISTER -- requirements
Module: dual_addressable_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the bit width of each entry, the data input and every output entry.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge except reset.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port sel, input, 2 bits: explicit entry address; also the pointer load value.
REQ-005 The block SHALL have port data, input, WIDTH bits: the value to write.
REQ-006 The block SHALL have port enable_n, input, 1 bit: active-low write enable.
REQ-007 The block SHALL have port clear_n, input, 1 bit: active-low clear/demux control.
REQ-008 The block SHALL have port use_ptr, input, 1 bit: 1 selects the internal pointer as the write address, 0 selects sel.
REQ-009 The block SHALL have port ptr_load, input, 1 bit: 1 loads the pointer from sel.
REQ-010 The block SHALL have ports out0, out1, out2 and out3, output, WIDTH bits each: the stored entries 0-3, directly from registers.
REQ-011 The block SHALL have port ptr, output, 2 bits: the current pointer value.
REQ-012 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse on pointer wrap.

Function
REQ-013 The effective address addr SHALL be ptr when use_ptr=1, else sel, evaluated combinationally before the clock edge.
REQ-014 Each rising clock edge SHALL apply the mode selected by {clear_n, enable_n}.
- 11 HOLD: all entries unchanged.
- 10 WRITE: entry[addr] <= data; the other entries hold.
- 01 CLEAR: all entries <= 0; data and addr are ignored.
- 00 DEMUX: entry[addr] <= data; the other three entries <= 0.
REQ-015 A write cycle SHALL be a WRITE or DEMUX edge; HOLD and CLEAR SHALL NOT be write cycles.
REQ-016 On a write cycle with use_ptr=1 and ptr_load=0, ptr SHALL be updated to (ptr+1) mod 4.
REQ-017 ptr_load=1 SHALL set ptr <= sel on that edge, taking priority over the increment in every mode.
REQ-018 When ptr_load=1 and use_ptr=1 on the same edge, the write SHALL use the old ptr, and ptr SHALL become sel with no increment.
REQ-019 wrap SHALL be 1 for exactly the cycle after an edge on which ptr incremented from 3 to 0.
REQ-020 wrap SHALL be 0 otherwise, including when ptr_load sets ptr to 0.
REQ-021 With use_ptr=0, ptr SHALL change only via ptr_load.
REQ-022 Write latency SHALL be one edge: the new entry value appears on outN immediately after the write edge.
REQ-023 outN SHALL NOT be combinationally dependent on any input.
REQ-024 The block SHALL produce no X on any output after reset for any known input combination.

Reset
REQ-025 While reset=1, the block SHALL hold out0-out3=0, ptr=0 and wrap=0 immediately, without waiting for a clock edge.
REQ-026 While reset=1, the block SHALL ignore all clock edges.
REQ-027 Reset asserted mid-sequence SHALL discard any pending pointer increment or wrap pulse.
REQ-028 The first edge after reset deasserts SHALL operate normally from the reset state.

Verification
REQ-029 Scenario (explicit write and hold):
- Stimulus: reset; then WRITE sel=2, data=2'b11; then HOLD with data=2'b01.
- Required response: out2=3, others 0; values unchanged after the HOLD edge.
REQ-030 Scenario (demux and clear):
- Stimulus: entries preloaded 1,2,3,1; then DEMUX sel=1, data=2; then CLEAR.
- Required response: after DEMUX, outputs 0,2,0,0; after CLEAR, all 0.
REQ-031 Scenario (pointer fill and wrap):
- Stimulus: ptr_load sel=3, use_ptr=0; then four WRITE edges with use_ptr=1, data 1,2,3,0.
- Required response: ptr 3->0->1->2->3; out3=1, out0=2, out1=3, out2=0; wrap=1 only in the cycle after the first write.
REQ-032 Scenario (load/increment collision):
- Stimulus: ptr=1; one edge with WRITE, use_ptr=1, ptr_load=1, sel=3, data=2.
- Required response: out1=2; ptr=3; wrap=0.
REQ-033 Scenario (async reset mid-operation):
- Stimulus: ptr=3 with a pointer WRITE on the edge; assert reset 1 ns after the edge, between edges.
- Required response: outputs, ptr and wrap go to 0 at once with no clock; wrap stays 0 on the following cycles.
REQ-034 Scenario (non-write modes):
- Stimulus: use_ptr=1, ptr=2; one HOLD edge and one CLEAR edge.
- Required response: ptr remains 2 throughout; wrap stays 0.
